// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external adder between two requesters
module adder_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             busy
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_n;
    logic cur_id, last_id, pick, acc;
    assign acc  = rst & (req0 | req1);
    assign pick = (req0 & req1) ? ~last_id : req1;
    assign gnt0 = acc & ~pick;
    assign gnt1 = acc & pick;
    assign busy = state == EXEC;
    always_comb begin
        state_n = acc ? EXEC : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            add_a     <= '0;
            add_b     <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            cur_id    <= 1'b0;
            last_id   <= 1'b1;
        end else begin
            state     <= state_n;
            res_valid <= busy;
            if (acc) begin
                add_a   <= pick ? a1 : a0;
                add_b   <= pick ? b1 : b0;
                cur_id  <= pick;
                last_id <= pick;
            end
            if (busy) begin
                res_sum  <= add_sum;
                res_cout <= add_cout;
                res_ovf  <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
                res_id   <= cur_id;
            end
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed self-checking bench with a behavioural adder attached
module tb_adder_share_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, res_valid, res_id, res_cout, res_ovf, busy, add_cout;
    logic [31:0] add_a, add_b, add_sum, res_sum;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    adder_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout),
        .res_ovf(res_ovf), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1; a0 = 32'h11; b0 = 32'h22;
        step(); step();
        checks++;
        if ({gnt0, gnt1, busy, res_valid, res_id, res_cout, res_ovf} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000000", {gnt0, gnt1, busy, res_valid, res_id, res_cout, res_ovf});
        end
        checks++;
        if ({add_a, add_b, res_sum} !== 96'b0) begin
            errors++; $display("FAIL reset_data got %h %h %h want zeros", add_a, add_b, res_sum);
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
        step();
    endtask

    task automatic test_contention();
        req0 = 1'b1; req1 = 1'b1; a0 = 32'd10; b0 = 32'd1; a1 = 32'd20; b1 = 32'd2;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
            #1;
            checks++;
            if ({gnt0, gnt1} !== (k < 4 ? (k % 2 == 0 ? 2'b10 : 2'b01) : 2'b00)) begin
                errors++; $display("FAIL contention_gnt k=%0d got %b%b", k, gnt0, gnt1);
            end
            checks++;
            if (res_valid !== (k >= 2)) begin
                errors++; $display("FAIL contention_valid k=%0d got %b want %b", k, res_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (res_id !== 1'((k - 2) % 2) || res_sum !== ((k - 2) % 2 == 0 ? 32'd11 : 32'd22)) begin
                    errors++; $display("FAIL contention_res k=%0d got id=%b sum=%0d", k, res_id, res_sum);
                end
            end
            step();
        end
    endtask

    task automatic test_arith();
        logic [31:0] va[4], vb[4], vs[4];
        logic        vc[4], vo[4];
        va = '{32'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        vb = '{32'd5, 32'h00000001, 32'h00000001, 32'h80000000};
        vs = '{32'd8, 32'h80000000, 32'h00000000, 32'h00000000};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1};
        vo = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; a0 = va[i]; b0 = vb[i];
            #1;
            checks++;
            if ({gnt0, gnt1} !== 2'b10) begin
                errors++; $display("FAIL arith_gnt i=%0d got %b%b want 10", i, gnt0, gnt1);
            end
            step();
            req0 = 1'b0;
            checks++;
            if (busy !== 1'b1 || add_a !== va[i] || add_b !== vb[i] || res_valid !== 1'b0) begin
                errors++; $display("FAIL arith_exec i=%0d got busy=%b a=%h b=%h v=%b", i, busy, add_a, add_b, res_valid);
            end
            step();
            checks++;
            if ({res_valid, res_id, res_cout, res_ovf, busy} !== {1'b1, 1'b0, vc[i], vo[i], 1'b0} || res_sum !== vs[i]) begin
                errors++; $display("FAIL arith_res i=%0d got v=%b id=%b c=%b o=%b busy=%b sum=%h want sum=%h c=%b o=%b",
                                   i, res_valid, res_id, res_cout, res_ovf, busy, res_sum, vs[i], vc[i], vo[i]);
            end
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 32'h0 || res_cout !== 1'b1 || res_ovf !== 1'b1) begin
            errors++; $display("FAIL arith_hold got v=%b sum=%h c=%b o=%b want 0 0 1 1", res_valid, res_sum, res_cout, res_ovf);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 5; k++) begin
            req0 = 1'b0;
            req1 = k < 3;
            a1 = 32'(k + 1); b1 = 32'(k + 1);
            #1;
            checks++;
            if ({gnt0, gnt1} !== {1'b0, k < 3} || busy !== (k >= 1 && k <= 3)) begin
                errors++; $display("FAIL b2b_ctl k=%0d got gnt=%b%b busy=%b", k, gnt0, gnt1, busy);
            end
            checks++;
            if (res_valid !== (k >= 2) || (k >= 2 && (res_sum !== 32'(2 * (k - 1)) || res_id !== 1'b1))) begin
                errors++; $display("FAIL b2b_res k=%0d got v=%b sum=%0d id=%b want sum=%0d", k, res_valid, res_sum, res_id, 2 * (k - 1));
            end
            step();
        end
    endtask

    task automatic test_reset_midop();
        req0 = 1'b1; a0 = 32'd100; b0 = 32'd200;
        step();
        req0 = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midop_busy got %b want 1", busy);
        end
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, busy, res_valid, res_id, res_cout, res_ovf} !== 7'b0 || {add_a, add_b, res_sum} !== 96'b0) begin
            errors++; $display("FAIL midop_reset got flags=%b a=%h b=%h sum=%h", {gnt0, gnt1, busy, res_valid, res_id, res_cout, res_ovf}, add_a, add_b, res_sum);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midop_discard got v=%b busy=%b want 0 0", res_valid, busy);
        end
        rst = 1'b1; a1 = 32'd7; b1 = 32'd8;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL midop_first_contention got %b%b want 10", gnt0, gnt1);
        end
        step();
        req0 = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b01 || add_a !== 32'd100 || add_b !== 32'd200) begin
            errors++; $display("FAIL midop_req1_alone got gnt=%b%b a=%0d b=%0d", gnt0, gnt1, add_a, add_b);
        end
        step();
        req1 = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_sum !== 32'd300) begin
            errors++; $display("FAIL midop_res0 got v=%b id=%b sum=%0d want 1 0 300", res_valid, res_id, res_sum);
        end
        step();
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b1 || res_sum !== 32'd15) begin
            errors++; $display("FAIL midop_res1 got v=%b id=%b sum=%0d want 1 1 15", res_valid, res_id, res_sum);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_arith();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Sequencer and arbiter that shares one 32-bit ripple-carry adder between two requesters, for example the ALU add path and the branch-target / PC-offset path. It accepts one operand pair per cycle using round-robin priority and drives the operands into the external adder from registers. It captures sum, carry-out and signed overflow into result registers, then reports the result tagged with the winning requester's ID. The block sits between the requesters and the adder instance in the execute stage.

## Interface
Parameters:
- WIDTH, 32, datapath width; must equal the attached adder width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 has a valid operand pair; held until granted.
- a0, b0  in  WIDTH  requester 0 operands.
- req1  in  1  requester 1 request.
- a1, b1  in  WIDTH  requester 1 operands.
- gnt0, gnt1  out  1  combinational accept strobe; operands are latched at the end of this cycle.
- add_a, add_b  out  WIDTH  registered operands driving the shared adder.
- add_sum  in  WIDTH  adder sum (combinational from add_a/add_b).
- add_cout  in  1  adder carry-out.
- res_valid  out  1  one-cycle pulse; result registers are valid.
- res_id  out  1  requester that owns the result (0/1).
- res_sum  out  WIDTH  registered sum.
- res_cout  out  1  registered carry-out.
- res_ovf  out  1  registered signed overflow.
- busy  out  1  high while an operation is in the adder (state EXEC).

## Operation
- FSM states: IDLE and EXEC. Reset state is IDLE.
- Accept: in either state, if req0 or req1 is high, exactly one gnt is asserted. At that edge:
  - the winner's operands load into add_a/add_b;
  - the winner's ID loads into cur_id;
  - the FSM goes to EXEC.
- IDLE with no request: stay in IDLE; add_a/add_b hold their values.
- EXEC: the adder settles during this cycle. At the end of the cycle:
  - res_sum ← add_sum and res_cout ← add_cout;
  - res_ovf ← (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]). The block computes this itself and does not use an overflow flag from the adder.
  - res_id ← cur_id; res_valid pulses for the next cycle.
- EXEC with a new accept in the same cycle: the result is captured and the new operands are loaded at the same edge. The FSM stays in EXEC, giving one operation per cycle back-to-back.
- EXEC with no accept: return to IDLE.
- Arbitration:
  - Only one request high: it wins.
  - Both high: the requester ≠ last_id wins; last_id updates on every accept.
  - last_id resets to 1, so requester 0 wins the first contention.
- A requester that keeps req high after gnt is treated as issuing a new request, not as a duplicate.
- Arithmetic: unsigned modulo-2^WIDTH sum. Carry and overflow are independent; both may be set, e.g. 0x80000000 + 0x80000000 gives sum 0, cout 1, ovf 1.

## Timing
- Request accepted in cycle N (gnt high in N) → add_a/add_b valid in N+1 → res_valid high in N+2 only. Latency is 2 cycles.
- Throughput is 1 operation per cycle under continuous requests. Under contention each requester gets every other slot.
- gnt is combinational from req and last_id. There is no combinational path from a*/b* to any output.
- res_* hold their values between pulses and update only on the EXEC capture edge.
- Reset (rst low, any time, asynchronous):
  - state → IDLE;
  - add_a, add_b, res_sum → 0;
  - res_cout, res_ovf, res_valid, res_id, cur_id → 0;
  - last_id → 1; busy → 0;
  - gnt0 and gnt1 are forced to 0 while rst is low.
- Reset mid-operation: an in-flight operation is discarded and no res_valid is produced for it.
- The first accept can occur in the first cycle after rst deasserts.

## Test plan
- Single request: req0 with a0=3, b0=5 for one cycle → gnt0 in N; res_valid in N+2 with res_sum=8, res_id=0, cout=0, ovf=0.
- Contention: req0 and req1 held high for 4 cycles → grant order 0,1,0,1; four res_valid pulses in consecutive cycles with matching res_id.
- Signed overflow: 0x7FFFFFFF + 0x00000001 → sum=0x80000000, ovf=1, cout=0.
- Carry wrap: 0xFFFFFFFF + 0x00000001 → sum=0, cout=1, ovf=0. Also 0x80000000 + 0x80000000 → sum=0, cout=1, ovf=1.
- Back-to-back single requester: req1 held 3 cycles with operands changing each cycle (1+1, 2+2, 3+3) → busy high 3 cycles; results 2, 4, 6 on three consecutive cycles.
- Reset mid-op: rst pulsed low in the EXEC cycle → no res_valid; all outputs at reset values; the next req1 alone is granted immediately. With both requests high after reset, req0 wins.
